// File: rtl/regfile_pkg.sv
// Shared definitions for the regfile_sb register file.
//   - default data/address widths
//   - depth derivation from the address width
//   - idx_slice: base bit of field i in a packed multi-port bus
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    // Number of registers addressable with addr_w bits.
    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

    localparam int DEPTH_DEF = depth_of(ADDR_W_DEF);

    // Base bit of field i when fields of width w are packed side by side.
    function automatic int idx_slice(input int i, input int w);
        return i * w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write scoreboard.
// A bit is set when an instruction targeting that register issues and
// cleared when its writeback arrives. pend_cnt tracks the number of set
// bits as an up/down counter, so it never needs a popcount tree.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   issue_en, issue_addr   destination of the issuing instruction
//   wr_en, wr_addr         writeback destination
//   flush                  clear every pending bit
//   pend                   registered pending vector, one bit per register
//   pend_cnt               registered count of set pending bits
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         issue_en,
    input  logic [ADDR_W-1:0]            issue_addr,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic                         flush,
    output logic [depth_of(ADDR_W)-1:0]  pend,
    output logic [ADDR_W:0]              pend_cnt
);

    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

    logic                         set_ok;
    logic                         clr_ok;
    logic                         inc;
    logic                         dec;
    logic [depth_of(ADDR_W)-1:0]  pend_next;

    always_comb begin
        // NOTE: every variable gets a default first so no path through the
        // block leaves it unassigned, which would infer a latch.
        set_ok    = issue_en && !(ZERO_REG != 0 && issue_addr == '0);
        // A newer producer issuing to the same register keeps it pending.
        clr_ok    = wr_en && !(set_ok && issue_addr == wr_addr);
        inc       = set_ok && !pend[issue_addr];
        dec       = clr_ok && pend[wr_addr];
        pend_next = pend;
        if (clr_ok) pend_next[wr_addr]    = 1'b0;
        if (set_ok) pend_next[issue_addr] = 1'b1;
        if (flush)  pend_next             = '0;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            pend <= pend_next;
            if (flush)
                pend_cnt <= '0;
            else if (inc && !dec)
                pend_cnt <= pend_cnt + CNT_ONE;
            else if (dec && !inc)
                pend_cnt <= pend_cnt - CNT_ONE;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with hardwired zero register, same-cycle write bypass and
// a pending-write scoreboard feeding the hazard unit.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   rd_addr / rd_data     N_READ packed combinational read ports
//   rd_pending            per read port: register has an outstanding producer
//   wr_en/wr_addr/wr_data synchronous writeback port
//   issue_en/issue_addr   destination of the issuing instruction
//   flush                 clear all pending bits, data kept
//   pend_cnt              registered number of pending registers
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int N_READ   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_READ*ADDR_W-1:0]   rd_addr,
    output logic [N_READ*DATA_W-1:0]   rd_data,
    output logic [N_READ-1:0]          rd_pending,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       issue_en,
    input  logic [ADDR_W-1:0]          issue_addr,
    input  logic                       flush,
    output logic [ADDR_W:0]            pend_cnt
);

    localparam int DEPTH = depth_of(ADDR_W);

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [DEPTH-1:0]   pend;
    logic               wr_ok;
    logic [ADDR_W-1:0]  addr;
    logic               hit;

    assign wr_ok = wr_en && !(ZERO_REG != 0 && wr_addr == '0);

    always_ff @(posedge clk) begin
        // NOTE: the storage array is reset explicitly because a reset must
        // leave every register reading as zero, not just the control state.
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .flush      (flush),
        .pend       (pend),
        .pend_cnt   (pend_cnt)
    );

    // Read ports: zero register and reset force 0; a same-cycle write to the
    // read address forwards its data and retires the pending flag.
    always_comb begin
        rd_data    = '0;
        rd_pending = '0;
        addr       = '0;
        hit        = 1'b0;
        for (int i = 0; i < N_READ; i++) begin
            addr = rd_addr[idx_slice(i, ADDR_W) +: ADDR_W];
            hit  = (BYPASS != 0) && wr_en && (wr_addr == addr);
            if (rst_n && !(ZERO_REG != 0 && addr == '0)) begin
                rd_data[idx_slice(i, DATA_W) +: DATA_W] = hit ? wr_data : mem[addr];
                rd_pending[i] = pend[addr] && !hit;
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb. A bypassing instance (dut)
// and a non-bypassing instance (dut_nb) share all stimulus.
module tb_regfile_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int N_READ = 2;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [N_READ*ADDR_W-1:0]  rd_addr;
    logic [N_READ*DATA_W-1:0]  rd_data;
    logic [N_READ*DATA_W-1:0]  rd_data_nb;
    logic [N_READ-1:0]         rd_pending;
    logic [N_READ-1:0]         rd_pending_nb;
    logic                      wr_en;
    logic [ADDR_W-1:0]         wr_addr;
    logic [DATA_W-1:0]         wr_data;
    logic                      issue_en;
    logic [ADDR_W-1:0]         issue_addr;
    logic                      flush;
    logic [ADDR_W:0]           pend_cnt;
    logic [ADDR_W:0]           pend_cnt_nb;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_READ(N_READ),
                 .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_pending(rd_pending), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .issue_en(issue_en), .issue_addr(issue_addr),
        .flush(flush), .pend_cnt(pend_cnt)
    );

    regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_READ(N_READ),
                 .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_nb),
        .rd_pending(rd_pending_nb), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .issue_en(issue_en), .issue_addr(issue_addr),
        .flush(flush), .pend_cnt(pend_cnt_nb)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are
    // sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; issue_en = 1'b0; flush = 1'b0;
    endtask

    task automatic set_rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    function automatic logic [DATA_W-1:0] port(input logic [N_READ*DATA_W-1:0] bus, input int i);
        return bus[i*DATA_W +: DATA_W];
    endfunction

    initial begin
        rst_n = 1'b0; rd_addr = '0; wr_addr = '0; wr_data = '0;
        issue_addr = '0; idle();
        step(); step();
        rst_n = 1'b1;

        // Reset state
        set_rd(5, 5); #1;
        check("reset_data0", port(rd_data, 0), 32'h0);
        check("reset_pend", rd_pending, 2'b00);
        check("reset_cnt", pend_cnt, 6'd0);

        // Plain write then read on both ports
        wr_en = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF;
        step(); idle(); #1;
        check("r5_port0", port(rd_data, 0), 32'hDEADBEEF);
        check("r5_port1", port(rd_data, 1), 32'hDEADBEEF);
        check("r5_pend", rd_pending, 2'b00);

        // Zero register: write and issue to r0 have no effect
        wr_en = 1'b1; wr_addr = 0; wr_data = 32'h1234;
        issue_en = 1'b1; issue_addr = 0;
        step(); idle(); set_rd(0, 0); #1;
        check("r0_data", port(rd_data, 0), 32'h0);
        check("r0_pend", rd_pending, 2'b00);
        check("r0_cnt", pend_cnt, 6'd0);

        // Bypass vs no bypass on a same-cycle write
        set_rd(5, 7);
        wr_en = 1'b1; wr_addr = 7; wr_data = 32'hA5A5A5A5; #1;
        check("bypass_r7", port(rd_data, 1), 32'hA5A5A5A5);
        check("nobypass_r7", port(rd_data_nb, 1), 32'h0);
        step(); idle(); #1;
        check("nobypass_r7_later", port(rd_data_nb, 1), 32'hA5A5A5A5);

        // Scoreboard: issue r3, r4
        issue_en = 1'b1; issue_addr = 3; step();
        issue_addr = 4; step(); idle();
        set_rd(3, 4); #1;
        check("cnt_after_2_issues", pend_cnt, 6'd2);
        check("pend_r3_r4", rd_pending, 2'b11);

        // Writeback r3: bypass retires the flag in the same cycle
        wr_en = 1'b1; wr_addr = 3; wr_data = 32'h33; #1;
        check("wb_r3_pend_bypass", rd_pending[0], 1'b0);
        check("wb_r3_pend_nobypass", rd_pending_nb[0], 1'b1);
        step(); idle(); #1;
        check("cnt_after_wb_r3", pend_cnt, 6'd1);
        check("pend_after_wb_r3", rd_pending, 2'b10);

        // Re-issue r4 while pending: count unchanged
        issue_en = 1'b1; issue_addr = 4; step(); idle(); #1;
        check("cnt_reissue_r4", pend_cnt, 6'd1);

        // Issue r9, then issue and writeback r9 together
        issue_en = 1'b1; issue_addr = 9; step(); idle(); #1;
        check("cnt_issue_r9", pend_cnt, 6'd2);
        issue_en = 1'b1; issue_addr = 9;
        wr_en = 1'b1; wr_addr = 9; wr_data = 32'h99;
        step(); idle(); set_rd(9, 3); #1;
        check("cnt_issue_wb_r9", pend_cnt, 6'd2);
        check("pend_r9_kept", rd_pending[0], 1'b1);
        check("data_r9", port(rd_data, 0), 32'h99);

        // Flush clears pending, keeps data
        flush = 1'b1; step(); idle(); set_rd(9, 4); #1;
        check("cnt_flush", pend_cnt, 6'd0);
        check("pend_flush", rd_pending, 2'b00);
        check("data_r9_after_flush", port(rd_data, 0), 32'h99);
        set_rd(3, 7); #1;
        check("data_r3_after_flush", port(rd_data, 0), 32'h33);
        check("data_r7_after_flush", port(rd_data, 1), 32'hA5A5A5A5);

        // Reset mid-operation
        wr_en = 1'b1; wr_addr = 2; wr_data = 32'h55; step(); idle();
        issue_en = 1'b1; issue_addr = 10; step();
        issue_addr = 11; step();
        issue_addr = 12; step(); idle();
        set_rd(2, 11); #1;
        check("cnt_three_pending", pend_cnt, 6'd3);
        check("data_r2_before_reset", port(rd_data, 0), 32'h55);
        check("pend_r11_before_reset", rd_pending[1], 1'b1);

        rst_n = 1'b0; wr_en = 1'b1; wr_addr = 2; wr_data = 32'h77; #1;
        check("rd_forced_zero_in_reset", port(rd_data, 0), 32'h0);
        check("pend_forced_zero_in_reset", rd_pending, 2'b00);
        step();
        rst_n = 1'b1; idle(); #1;
        check("cnt_after_reset", pend_cnt, 6'd0);
        check("r2_after_reset", port(rd_data, 0), 32'h0);
        check("pend_after_reset", rd_pending, 2'b00);
        set_rd(5, 9); #1;
        check("r5_after_reset", port(rd_data, 0), 32'h0);
        check("r9_after_reset", port(rd_data, 1), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
